// File: rtl/acc_readout.sv
`default_nettype none
// ============================================================================
// Module   : acc_readout
// Brief    : Snapshots N accumulator lanes on start and streams them out one
//            lane per transfer over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module acc_readout #(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int IDXW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic [N*WIDTH-1:0]   acc_in,
    output logic                 busy,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDXW-1:0]      out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 done
);

    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  w_lane   [N];
    logic [WIDTH-1:0]  r_shadow [N];
    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   w_idx_inc;
    logic [WIDTH-1:0]  r_data;
    logic              r_last;
    logic              r_done;
    logic              w_send;
    logic              w_hs;
    logic              w_at_last;

    // Split the flat accumulator bus into per-lane words.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign w_lane[i] = acc_in[i*WIDTH +: WIDTH];
    end

    assign w_send    = (r_state == ST_SEND);
    assign w_hs      = w_send & out_ready;
    assign w_at_last = (r_idx == c_LAST_IDX);
    assign w_idx_inc = r_idx + IDXW'(1);

    // State register; clear forces IDLE regardless of start or handshake.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: enter SEND on start, leave after the last lane is taken.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)            w_state_next = ST_SEND;
            ST_SEND: if (w_hs && w_at_last) w_state_next = ST_IDLE;
            default:                        w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: snapshot capture, lane pointer and registered output word.
    // out_data is preloaded with the next lane on each handshake so it
    // stays registered and holds steady while the sink stalls.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_idx  <= '0;
            r_data <= '0;
            r_last <= 1'b0;
            r_done <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_done <= w_hs & w_at_last;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            r_shadow[i] <= w_lane[i];
                        end
                        r_idx  <= '0;
                        r_data <= w_lane[0];
                        r_last <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        if (w_at_last) begin
                            r_idx  <= '0;
                            r_last <= 1'b0;
                        end else begin
                            r_idx  <= w_idx_inc;
                            r_data <= r_shadow[w_idx_inc];
                            r_last <= (w_idx_inc == c_LAST_IDX);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = w_send;
    assign out_valid = w_send;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign done      = r_done;

endmodule
`default_nettype wire
